// File: rtl/calc_pkg.sv
// Operator and state types plus the single-cycle evaluation helper for calc_engine.
package calc_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MUL  = 3'd3,
    OP_DIV  = 3'd4,
    OP_EQ   = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DIV  = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam int unsigned EVAL_W = 64;

  // Inputs are zero-extended accumulator/operand values. Any set bit above the
  // caller's WIDTH then means carry, borrow (wraps to all ones) or mul overflow.
  function automatic logic [EVAL_W-1:0] eval(input logic [EVAL_W-1:0] a,
                                             input logic [EVAL_W-1:0] b,
                                             input op_e               op);
    logic [EVAL_W-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_MUL:  r = a * b;
      OP_EQ:   r = a;
      default: r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/calc_divider.sv
// Restoring divider: one quotient bit per cycle, WIDTH cycles per divide,
// with the first bit resolved on the start cycle itself.
module calc_divider #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] quotient
);

  localparam int unsigned    CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] rem_in, quo_in, dvs_in, rem_nxt, quo_nxt;
  logic [WIDTH:0]   trial;
  logic [CW-1:0]    cnt_q;
  logic             run_q, valid_q, qbit;

  always_comb begin
    rem_in  = start ? '0 : rem_q;
    quo_in  = start ? dividend : quo_q;
    dvs_in  = start ? divisor : dvs_q;
    trial   = {rem_in, quo_in[WIDTH-1]} - {1'b0, dvs_in};
    qbit    = ~trial[WIDTH];
    rem_nxt = qbit ? trial[WIDTH-1:0] : {rem_in[WIDTH-2:0], quo_in[WIDTH-1]};
    quo_nxt = {quo_in[WIDTH-2:0], qbit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (abort) begin
      cnt_q   <= '0;
      run_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (start) begin
      rem_q   <= rem_nxt;
      quo_q   <= quo_nxt;
      dvs_q   <= divisor;
      cnt_q   <= CW'(1);
      run_q   <= 1'b1;
      valid_q <= 1'b0;
    end else if (run_q) begin
      rem_q   <= rem_nxt;
      quo_q   <= quo_nxt;
      valid_q <= (cnt_q == LAST);
      run_q   <= (cnt_q != LAST);
      cnt_q   <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign busy     = run_q;
  assign valid    = valid_q;
  assign quotient = quo_q;

endmodule

// File: rtl/calc_engine.sv
// Accumulator calculator core applying the pending operator when the next one arrives.
// Optional CALC_SAT_EN: saturate on overflow instead of wrapping.
//
// state   | meaning
// IDLE    | waiting for an operator strobe
// EXEC    | done pulse after a single-cycle op or divide; strobes still accepted
// DIV     | divider running, busy_o high, strobes dropped
// ERR     | divide by zero seen, locked until clr_i
module calc_engine
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] operand_i,
  input  logic [2:0]       op_i,
  input  logic             op_valid_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o,
  output logic             err_o
);

  state_e            state_q, state_d;
  op_e               pend_q, pend_d;
  logic [WIDTH-1:0]  acc_q, acc_d, res_w, quotient;
  logic              ovf_q, ovf_d, err_q, err_d, done_q, done_d;
  logic              ovf_w, div_start, div_busy, div_valid;
  logic [EVAL_W-1:0] raw;

  assign raw   = eval(EVAL_W'(acc_q), EVAL_W'(operand_i), pend_q);
  assign ovf_w = |raw[EVAL_W-1:WIDTH];

`ifdef CALC_SAT_EN
  assign res_w = ovf_w ? ((pend_q == OP_SUB) ? '0 : '1) : raw[WIDTH-1:0];
`else
  assign res_w = raw[WIDTH-1:0];
`endif

  calc_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .abort    (clr_i),
    .dividend (acc_q),
    .divisor  (operand_i),
    .busy     (div_busy),
    .valid    (div_valid),
    .quotient (quotient)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    pend_d    = pend_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    done_d    = 1'b0;
    div_start = 1'b0;
    if (clr_i) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      pend_d  = OP_NONE;
      ovf_d   = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_EXEC: begin
          state_d = ST_IDLE;
          if (op_valid_i) begin
            pend_d = op_e'(op_i);
            if (pend_q == OP_DIV) begin
              if (operand_i == '0) begin
                err_d   = 1'b1;
                done_d  = 1'b1;
                state_d = ST_ERR;
              end else begin
                div_start = 1'b1;
                state_d   = ST_DIV;
              end
            end else begin
              acc_d   = res_w;
              ovf_d   = ovf_q | ovf_w;
              done_d  = 1'b1;
              state_d = ST_EXEC;
            end
          end
        end
        ST_DIV: begin
          if (div_valid) begin
            acc_d   = quotient;
            done_d  = 1'b1;
            state_d = ST_EXEC;
          end
        end
        ST_ERR:  state_d = ST_ERR;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      pend_q  <= OP_NONE;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign result_o = acc_q;
  assign busy_o   = (state_q == ST_DIV) | div_busy;
  assign done_o   = done_q;
  assign ovf_o    = ovf_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_calc_engine.sv
// Self-checking bench for calc_engine: directed scenarios plus random operator chains
// compared against an arithmetic reference model.
module tb_calc_engine;

  localparam int W = 10;
  localparam longint unsigned MASK = (64'd1 << W) - 64'd1;
  localparam int unsigned MASKI = (32'd1 << W) - 32'd1;

  logic         clk = 1'b0;
  logic         rst_n, clr_i, op_valid_i;
  logic [W-1:0] operand_i, result_o;
  logic [2:0]   op_i;
  logic         busy_o, done_o, ovf_o, err_o;

  int n_vec = 0;
  int n_err = 0;

  longint unsigned m_acc = 0;
  int unsigned     m_pend = 0;
  bit              m_ovf = 0, m_err = 0;

  calc_engine #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .clr_i(clr_i), .operand_i(operand_i), .op_i(op_i),
    .op_valid_i(op_valid_i), .result_o(result_o), .busy_o(busy_o), .done_o(done_o),
    .ovf_o(ovf_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns 0 = strobe ignored (locked), 1 = single-cycle op, 2 = divide, 3 = divide by zero.
  function automatic int model_step(input longint unsigned b, input int unsigned op);
    longint unsigned a = m_acc;
    longint unsigned r = 0;
    bit o = 0;
    if (m_err) return 0;
    if (m_pend == 4) begin
      m_pend = op;
      if (b == 0) begin
        m_err = 1;
        return 3;
      end
      m_acc = a / b;
      return 2;
    end
    case (m_pend)
      1: begin r = a + b; o = (r > MASK); end
      2: begin r = (a - b) & MASK; o = (b > a); end
      3: begin r = a * b; o = (r > MASK); end
      5: begin r = a; o = 0; end
      default: begin r = b; o = 0; end
    endcase
`ifdef CALC_SAT_EN
    if (o) r = (m_pend == 2) ? 64'd0 : MASK;
`endif
    m_acc  = r & MASK;
    m_ovf  = m_ovf | o;
    m_pend = op;
    return 1;
  endfunction

  task automatic model_clear();
    m_acc = 0; m_pend = 0; m_ovf = 0; m_err = 0;
  endtask

  task automatic do_clr(input bit with_op);
    @(negedge clk);
    clr_i = 1'b1;
    op_valid_i = with_op;
    @(negedge clk);
    clr_i = 1'b0;
    op_valid_i = 1'b0;
    model_clear();
    chk("clr_result", 64'(result_o), 64'd0);
    chk("clr_ovf", 64'(ovf_o), 64'd0);
    chk("clr_err", 64'(err_o), 64'd0);
    chk("clr_busy", 64'(busy_o), 64'd0);
    chk("clr_done", 64'(done_o), 64'd0);
  endtask

  task automatic apply(input longint unsigned opnd, input int unsigned op, input bit poke);
    int kind, busy_n, lat;
    bit got;
    kind = model_step(opnd, op);
    @(negedge clk);
    operand_i  = W'(opnd);
    op_i       = 3'(op);
    op_valid_i = 1'b1;
    @(negedge clk);
    op_valid_i = 1'b0;
    if (kind == 2) begin
      busy_n = 0; lat = 1; got = 0;
      while (!got && lat < 4 * W) begin
        if (done_o) got = 1;
        else begin
          if (busy_o) busy_n++;
          op_valid_i = poke && (lat == 3);
          @(negedge clk);
          lat++;
        end
      end
      op_valid_i = 1'b0;
      chk("div_done_seen", 64'(got), 64'd1);
      chk("div_busy_cycles", 64'(busy_n), 64'(W));
      chk("div_latency", 64'(lat), 64'(W + 1));
    end else begin
      chk("done_pulse", 64'(done_o), (kind == 0) ? 64'd0 : 64'd1);
    end
    chk("result", 64'(result_o), m_acc);
    chk("ovf", 64'(ovf_o), 64'(m_ovf));
    chk("err", 64'(err_o), 64'(m_err));
    chk("busy_after", 64'(busy_o), 64'd0);
    @(negedge clk);
    chk("done_single", 64'(done_o), 64'd0);
  endtask

  initial begin
    int kind, ndone;
    longint unsigned opnd;
    rst_n = 1'b0; clr_i = 1'b0; op_valid_i = 1'b0; operand_i = '0; op_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_result", 64'(result_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_ovf", 64'(ovf_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    rst_n = 1'b1;

    // chain 5 ADD, 7 SUB, 3 EQ
    apply(5, 1, 0);
    chk("chain_5", 64'(result_o), 64'd5);
    apply(7, 2, 0);
    chk("chain_12", 64'(result_o), 64'd12);
    apply(3, 5, 0);
    chk("chain_9", 64'(result_o), 64'd9);

    // 100 / 7 with a strobe dropped while busy
    do_clr(0);
    apply(100, 4, 0);
    apply(7, 5, 1);
    chk("div_14", 64'(result_o), 64'd14);

    // divide by zero locks until clear
    do_clr(0);
    apply(9, 4, 0);
    apply(0, 5, 0);
    chk("dz_err", 64'(err_o), 64'd1);
    chk("dz_result", 64'(result_o), 64'd9);
    apply(3, 1, 0);
    chk("dz_locked", 64'(result_o), 64'd9);
    do_clr(0);

    // mul overflow and sub borrow
    apply(1000, 3, 0);
    apply(2, 5, 0);
`ifdef CALC_SAT_EN
    chk("mul_ovf_val", 64'(result_o), 64'd1023);
`else
    chk("mul_ovf_val", 64'(result_o), 64'd976);
`endif
    chk("mul_ovf_flag", 64'(ovf_o), 64'd1);
    do_clr(0);
    apply(3, 2, 0);
    apply(5, 5, 0);
`ifdef CALC_SAT_EN
    chk("borrow_val", 64'(result_o), 64'd0);
`else
    chk("borrow_val", 64'(result_o), 64'd1022);
`endif
    chk("borrow_flag", 64'(ovf_o), 64'd1);

    // clr together with a strobe: clear wins
    apply(4, 1, 0);
    do_clr(1);

    // back-to-back strobes
    kind = model_step(4, 1);
    @(negedge clk); operand_i = 4; op_i = 3'd1; op_valid_i = 1'b1;
    @(negedge clk);
    chk("b2b_done1", 64'(done_o), 64'd1);
    chk("b2b_res1", 64'(result_o), m_acc);
    kind = model_step(6, 3);
    operand_i = 6; op_i = 3'd3;
    @(negedge clk); op_valid_i = 1'b0;
    chk("b2b_done2", 64'(done_o), 64'd1);
    chk("b2b_res2", 64'(result_o), m_acc);
    @(negedge clk);
    chk("b2b_done_end", 64'(done_o), 64'd0);

    // clr at divide cycle 4 aborts without done
    do_clr(0);
    apply(50, 4, 0);
    @(negedge clk); operand_i = 5; op_i = 3'd5; op_valid_i = 1'b1;
    @(negedge clk); op_valid_i = 1'b0;
    chk("abort_busy_pre", 64'(busy_o), 64'd1);
    repeat (3) @(negedge clk);
    clr_i = 1'b1;
    @(negedge clk); clr_i = 1'b0;
    model_clear();
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_result", 64'(result_o), 64'd0);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done_o || busy_o) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", 64'(ndone), 64'd0);

    // async reset while in EXEC
    kind = model_step(7, 1);
    @(negedge clk); operand_i = 7; op_i = 3'd1; op_valid_i = 1'b1;
    @(posedge clk); #1; op_valid_i = 1'b0;
    chk("exec_done", 64'(done_o), 64'd1);
    chk("exec_result", 64'(result_o), m_acc);
    rst_n = 1'b0; #1;
    chk("arst_result", 64'(result_o), 64'd0);
    chk("arst_done", 64'(done_o), 64'd0);
    chk("arst_ovf", 64'(ovf_o), 64'd0);
    chk("arst_err", 64'(err_o), 64'd0);
    chk("arst_busy", 64'(busy_o), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    model_clear();

    // random operator chains
    for (int k = 0; k < 80; k++) begin
      if (m_err || $urandom_range(0, 19) == 0) do_clr(0);
      opnd = ($urandom_range(0, 7) == 0) ? 64'd0 : 64'($urandom_range(0, MASKI));
      apply(opnd, $urandom_range(0, 7), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
